// File: rtl/chip8_mem_responder_if.sv
// chip8_mem_responder_if
//   Request/response bus between chip-8 initiators (video/sprite engine, core)
//   and the memory responder.
//   req_valid  : request strobe, honoured only while ready=1
//   req_we     : 1=write, 0=read
//   req_type   : 0=program RAM, 1=VRAM framebuffer
//   req_addr   : 16-bit byte address
//   req_data   : write data
//   ready      : responder idle and able to accept
//   resp_valid : one-cycle pulse, resp_data valid
//   resp_data  : read data, held until the next response
interface chip8_mem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic        req_type;
   logic [15:0] req_addr;
   logic [7:0]  req_data;
   logic        ready;
   logic        resp_valid;
   logic [7:0]  resp_data;

   modport master (
      output req_valid, req_we, req_type, req_addr, req_data,
      input  ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_we, req_type, req_addr, req_data,
      output ready, resp_valid, resp_data
   );
endinterface

// File: rtl/chip8_mem_responder.sv
// chip8_mem_responder
//   Responder end of the chip-8 memory request protocol. Accepts one request
//   at a time, routes it to the program RAM (type 0) or the VRAM framebuffer
//   (type 1), drives the selected BRAM port and returns read data with a
//   single-cycle valid pulse. All outputs are registered.
// Ports:
//   clk_in, rst_in        : clock, synchronous active-high reset
//   bus (slave modport)   : request/response handshake
//   err_out               : sticky out-of-range address flag
//   ram_addr/we/din_out   : program RAM port, ram_dout_in read data
//   vram_addr/we/din_out  : VRAM port, vram_dout_in read data
module chip8_mem_responder #(
   parameter int  BRAM_LATENCY = 2,
   parameter int  RAM_DEPTH    = 4096,
   parameter int  VRAM_DEPTH   = 256,
   localparam int RAM_AW       = $clog2(RAM_DEPTH),
   localparam int VRAM_AW      = $clog2(VRAM_DEPTH)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   chip8_mem_responder_if.slave  bus,
   output logic                  err_out,
   output logic [RAM_AW-1:0]     ram_addr_out,
   output logic                  ram_we_out,
   output logic [7:0]            ram_din_out,
   input  logic [7:0]            ram_dout_in,
   output logic [VRAM_AW-1:0]    vram_addr_out,
   output logic                  vram_we_out,
   output logic [7:0]            vram_din_out,
   input  logic [7:0]            vram_dout_in
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ_WAIT = 2'd2,
      RESP      = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic                 type_q, type_d;
   logic                 ready_q, ready_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [7:0]           resp_data_q, resp_data_d;
   logic                 err_q, err_d;
   logic [RAM_AW-1:0]    ram_addr_q, ram_addr_d;
   logic                 ram_we_q, ram_we_d;
   logic [7:0]           ram_din_q, ram_din_d;
   logic [VRAM_AW-1:0]   vram_addr_q, vram_addr_d;
   logic                 vram_we_q, vram_we_d;
   logic [7:0]           vram_din_q, vram_din_d;

   logic accept;
   logic ram_oor;
   logic vram_oor;

   // ready_q is only ever high in IDLE, but it is also low for the first
   // IDLE cycle after reset, so it gates acceptance on its own.
   assign accept   = (state_q == IDLE) && ready_q && bus.req_valid;
   assign ram_oor  = 32'(bus.req_addr) >= 32'(RAM_DEPTH);
   assign vram_oor = 32'(bus.req_addr) >= 32'(VRAM_DEPTH);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      type_d       = type_q;
      ready_d      = ready_q;
      resp_data_d  = resp_data_q;
      err_d        = err_q;
      ram_addr_d   = ram_addr_q;
      ram_din_d    = ram_din_q;
      vram_addr_d  = vram_addr_q;
      vram_din_d   = vram_din_q;
      // write enables and the response strobe are single-cycle pulses
      ram_we_d     = 1'b0;
      vram_we_d    = 1'b0;
      resp_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               ready_d = 1'b0;
               type_d  = bus.req_type;
               cnt_d   = '0;
               state_d = bus.req_we ? WRITE : READ_WAIT;
               // out-of-range addresses flag an error but still wrap
               if (!bus.req_type) begin
                  ram_addr_d = bus.req_addr[RAM_AW-1:0];
                  if (bus.req_we) begin
                     ram_we_d  = 1'b1;
                     ram_din_d = bus.req_data;
                  end
                  if (ram_oor) err_d = 1'b1;
               end else begin
                  vram_addr_d = bus.req_addr[VRAM_AW-1:0];
                  if (bus.req_we) begin
                     vram_we_d  = 1'b1;
                     vram_din_d = bus.req_data;
                  end
                  if (vram_oor) err_d = 1'b1;
               end
            end
         end
         WRITE: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
         READ_WAIT: begin
            // cnt_q reaches BRAM_LATENCY on the edge the BRAM dout becomes
            // valid; the sample happens on the following edge.
            if (cnt_q == 3'(BRAM_LATENCY)) begin
               resp_data_d  = type_q ? vram_dout_in : ram_dout_in;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         RESP: begin
            ready_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         type_q       <= 1'b0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         err_q        <= 1'b0;
         ram_addr_q   <= '0;
         ram_we_q     <= 1'b0;
         ram_din_q    <= '0;
         vram_addr_q  <= '0;
         vram_we_q    <= 1'b0;
         vram_din_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         type_q       <= type_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         err_q        <= err_d;
         ram_addr_q   <= ram_addr_d;
         ram_we_q     <= ram_we_d;
         ram_din_q    <= ram_din_d;
         vram_addr_q  <= vram_addr_d;
         vram_we_q    <= vram_we_d;
         vram_din_q   <= vram_din_d;
      end
   end

   assign bus.ready      = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign err_out        = err_q;
   assign ram_addr_out   = ram_addr_q;
   assign ram_we_out     = ram_we_q;
   assign ram_din_out    = ram_din_q;
   assign vram_addr_out  = vram_addr_q;
   assign vram_we_out    = vram_we_q;
   assign vram_din_out   = vram_din_q;

endmodule

// File: tb/tb_chip8_mem_responder.sv
// tb_chip8_mem_responder
//   Drives randomized and directed requests into chip8_mem_responder with
//   behavioural BRAMs attached. Expected responses, write-port activity and
//   ready-return times are queued when a request is accepted and checked by
//   an independent monitor. A second instance with BRAM_LATENCY=1 checks the
//   latency parameter.
module tb_chip8_mem_responder;
   localparam int L          = 2;
   localparam int RAM_DEPTH  = 4096;
   localparam int VRAM_DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_mem = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- main DUT (BRAM_LATENCY = 2) ----------------
   chip8_mem_responder_if bus();
   logic        err;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_din, ram_dout;
   logic [7:0]  vram_addr;
   logic        vram_we;
   logic [7:0]  vram_din, vram_dout;

   chip8_mem_responder #(.BRAM_LATENCY(L), .RAM_DEPTH(RAM_DEPTH), .VRAM_DEPTH(VRAM_DEPTH)) dut (
      .clk_in(clk), .rst_in(rst), .bus(bus), .err_out(err),
      .ram_addr_out(ram_addr), .ram_we_out(ram_we), .ram_din_out(ram_din), .ram_dout_in(ram_dout),
      .vram_addr_out(vram_addr), .vram_we_out(vram_we), .vram_din_out(vram_din), .vram_dout_in(vram_dout)
   );

   // behavioural BRAMs: registered address, L cycles to dout
   logic [7:0] ram_mem [RAM_DEPTH];
   logic [7:0] vram_mem[VRAM_DEPTH];
   logic [7:0] ram_pipe [L];
   logic [7:0] vram_pipe[L];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < RAM_DEPTH; i++)  ram_mem[i]  <= 8'(i * 7 + 3);
         for (int i = 0; i < VRAM_DEPTH; i++) vram_mem[i] <= 8'(i * 13 + 1);
      end else begin
         if (ram_we)  ram_mem[ram_addr]   <= ram_din;
         if (vram_we) vram_mem[vram_addr] <= vram_din;
      end
      ram_pipe[0]  <= ram_mem[ram_addr];
      vram_pipe[0] <= vram_mem[vram_addr];
      for (int i = 1; i < L; i++) begin
         ram_pipe[i]  <= ram_pipe[i-1];
         vram_pipe[i] <= vram_pipe[i-1];
      end
   end
   assign ram_dout  = ram_pipe[L-1];
   assign vram_dout = vram_pipe[L-1];

   // ---------------- reference model ----------------
   logic [7:0] ram_model [int];
   logic [7:0] vram_model[int];
   bit         err_model = 1'b0;
   logic [7:0] last_rd   = 8'h00;

   function automatic logic [7:0] model_rd(bit t, int a);
      if (t) return vram_model.exists(a) ? vram_model[a] : 8'(a * 13 + 1);
      return ram_model.exists(a) ? ram_model[a] : 8'(a * 7 + 3);
   endfunction

   logic [7:0]  rd_data_q[$];
   int          rd_cyc_q[$];
   int          rdy_cyc_q[$];
   logic [24:0] wr_q[$];
   int          wr_cyc_q[$];

   task automatic flush();
      rd_data_q.delete(); rd_cyc_q.delete(); rdy_cyc_q.delete();
      wr_q.delete(); wr_cyc_q.delete();
   endtask

   // ---------------- monitor ----------------
   bit          prev_ready = 1'b0;
   logic [24:0] wr_act;
   always @(negedge clk) begin
      if (bus.resp_valid) begin
         if (rd_data_q.size() == 0) chk("spurious_resp", 32'(bus.resp_valid), 32'd0);
         else begin
            last_rd = rd_data_q[0];
            chk("resp_data", 32'(bus.resp_data), 32'(rd_data_q.pop_front()));
            chk("resp_cycle", cyc, rd_cyc_q.pop_front());
         end
      end
      if (bus.ready && !prev_ready) begin
         if (rdy_cyc_q.size() == 0) chk("spurious_ready", 32'(bus.ready), 32'd0);
         else chk("ready_cycle", cyc, rdy_cyc_q.pop_front());
      end
      prev_ready = bus.ready;
      if (ram_we || vram_we) begin
         chk("we_exclusive", 32'(ram_we & vram_we), 32'd0);
         wr_act = vram_we ? {1'b1, 8'h00, vram_addr, vram_din} : {1'b0, 4'h0, ram_addr, ram_din};
         if (wr_q.size() == 0) chk("spurious_we", wr_act, 32'd0);
         else begin
            chk("wr_port", 32'(wr_act), 32'(wr_q.pop_front()));
            chk("wr_cycle", cyc, wr_cyc_q.pop_front());
         end
      end
   end

   // Called at a negedge. While the responder is busy, junk requests are
   // held on the bus; none of them may be accepted.
   task automatic issue(bit we, bit t, int addr, logic [7:0] d);
      int a, wa, tries;
      tries = 0;
      while (!bus.ready) begin
         bus.req_valid = 1'b1;
         bus.req_we    = 1'($urandom);
         bus.req_type  = 1'($urandom);
         bus.req_addr  = 16'($urandom);
         bus.req_data  = 8'($urandom);
         @(negedge clk);
         tries++;
         if (tries > 50) begin
            chk("ready_timeout", 32'(bus.ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
         end
      end
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_type  = t;
      bus.req_addr  = 16'(addr);
      bus.req_data  = d;
      a  = cyc + 1;
      wa = t ? addr % VRAM_DEPTH : addr % RAM_DEPTH;
      if (addr >= (t ? VRAM_DEPTH : RAM_DEPTH)) err_model = 1'b1;
      if (we) begin
         if (t) vram_model[wa] = d; else ram_model[wa] = d;
         wr_q.push_back({t, 16'(wa), d});
         wr_cyc_q.push_back(a);
         rdy_cyc_q.push_back(a + 1);
      end else begin
         rd_data_q.push_back(model_rd(t, wa));
         rd_cyc_q.push_back(a + L + 1);
         rdy_cyc_q.push_back(a + L + 2);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("ready_low", 32'(bus.ready), 32'd0);
      chk("err", 32'(err), 32'(err_model));
      if (we) chk("resp_hold", 32'(bus.resp_data), 32'(last_rd));
   endtask

   task automatic check_reset_vals();
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ram", {ram_we, 3'b0, ram_addr, ram_din}, 32'd0);
      chk("rst_vram", {vram_we, 7'b0, vram_addr, vram_din}, 32'd0);
   endtask

   // ---------------- second DUT (BRAM_LATENCY = 1) ----------------
   chip8_mem_responder_if bus1();
   logic        err1;
   logic [11:0] ram1_addr;
   logic        ram1_we;
   logic [7:0]  ram1_din, ram1_dout;
   logic [7:0]  vram1_addr;
   logic        vram1_we;
   logic [7:0]  vram1_din, vram1_dout;

   chip8_mem_responder #(.BRAM_LATENCY(1), .RAM_DEPTH(RAM_DEPTH), .VRAM_DEPTH(VRAM_DEPTH)) dut1 (
      .clk_in(clk), .rst_in(rst), .bus(bus1), .err_out(err1),
      .ram_addr_out(ram1_addr), .ram_we_out(ram1_we), .ram_din_out(ram1_din), .ram_dout_in(ram1_dout),
      .vram_addr_out(vram1_addr), .vram_we_out(vram1_we), .vram_din_out(vram1_din), .vram_dout_in(vram1_dout)
   );

   // fixed-content single-cycle BRAMs: data is a function of the address
   always @(posedge clk) begin
      ram1_dout  <= ram1_addr[7:0] ^ 8'h3C;
      vram1_dout <= vram1_addr ^ 8'hC3;
   end

   // ---------------- stimulus ----------------
   initial begin
      int a, t, addr, tries;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_type = 1'b0;
      bus.req_addr = '0; bus.req_data = '0;
      bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_type = 1'b0;
      bus1.req_addr = '0; bus1.req_data = '0;

      repeat (3) @(negedge clk);
      init_mem = 1'b0;
      check_reset_vals();
      rdy_cyc_q.push_back(cyc + 1);
      rst = 1'b0;
      @(negedge clk);

      // RAM write then read back
      issue(1'b1, 1'b0, 16'h0200, 8'hA5);
      issue(1'b0, 1'b0, 16'h0200, 8'h00);
      // type isolation
      issue(1'b1, 1'b0, 16'h0010, 8'h11);
      issue(1'b1, 1'b1, 16'h0010, 8'h22);
      issue(1'b0, 1'b0, 16'h0010, 8'h00);
      issue(1'b0, 1'b1, 16'h0010, 8'h00);
      // range error: wraps to VRAM 0x05, err sticks
      issue(1'b1, 1'b1, 16'h0105, 8'hFF);
      issue(1'b0, 1'b1, 16'h0005, 8'h00);
      issue(1'b0, 1'b0, 16'h0FFF, 8'h00);
      issue(1'b1, 1'b0, 16'h0001, 8'h5C);

      // reset one cycle after a read is accepted
      issue(1'b0, 1'b0, 16'h0200, 8'h00);
      rst = 1'b1;
      flush();
      @(negedge clk);
      check_reset_vals();
      @(negedge clk);
      err_model = 1'b0;
      last_rd   = 8'h00;
      rdy_cyc_q.push_back(cyc + 1);
      rst = 1'b0;
      @(negedge clk);

      // randomized traffic; small address windows make reads hit writes
      for (int i = 0; i < 300; i++) begin
         t = $urandom_range(0, 1);
         case ($urandom_range(0, 7))
            0:       addr = $urandom_range(0, 65535);
            1, 2, 3: addr = $urandom_range(0, 15);
            default: addr = t ? $urandom_range(0, VRAM_DEPTH - 1) : $urandom_range(0, RAM_DEPTH - 1);
         endcase
         issue(1'($urandom_range(0, 1)), 1'(t), addr, 8'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // drain
      tries = 0;
      while ((rd_data_q.size() + rdy_cyc_q.size() + wr_q.size()) != 0 && tries < 20) begin
         @(negedge clk);
         tries++;
      end
      chk("drain_rd", rd_data_q.size(), 32'd0);
      chk("drain_rdy", rdy_cyc_q.size(), 32'd0);
      chk("drain_wr", wr_q.size(), 32'd0);

      // latency-1 instance: resp at A+2, ready at A+3
      for (int k = 0; k < 2; k++) begin
         bus1.req_valid = 1'b1;
         bus1.req_we    = 1'b0;
         bus1.req_type  = 1'(k);
         bus1.req_addr  = (k == 0) ? 16'h0123 : 16'h0047;
         chk("l1_ready_idle", 32'(bus1.ready), 32'd1);
         @(posedge clk);
         @(negedge clk);
         bus1.req_valid = 1'b0;
         chk("l1_busy_a1", {bus1.ready, bus1.resp_valid}, 32'd0);
         @(negedge clk);
         chk("l1_busy_a1b", {bus1.ready, bus1.resp_valid}, 32'd0);
         @(negedge clk);
         chk("l1_resp_valid", {bus1.ready, bus1.resp_valid}, 32'b01);
         chk("l1_resp_data", 32'(bus1.resp_data), (k == 0) ? 32'(8'h23 ^ 8'h3C) : 32'(8'h47 ^ 8'hC3));
         @(negedge clk);
         chk("l1_ready_back", {bus1.ready, bus1.resp_valid}, 32'b10);
      end
      chk("l1_quiet", {err1, ram1_we, vram1_we, ram1_din, vram1_din}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // global time limit
   initial begin
      a_timeout : begin
         #200000;
         $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
         $fatal(1);
      end
   end

endmodule

// File: doc/chip8_mem_responder.md
Name: chip8_mem_responder

Overview:
- Responder end of the chip-8 memory request protocol. Chip-8 initiators such as the video/sprite engine issue read and write requests over this protocol.
- Accepts one request at a time and decodes the type bit: 0 routes to the 4 KiB program RAM, 1 routes to the 256-byte VRAM framebuffer (64x32 bits, 8 bytes per row).
- Drives both BRAM ports and returns read data with a single-cycle valid pulse.
- Sits between one chip-8 core's initiators and its two BRAMs.

Parameters:
- BRAM_LATENCY, 2, read latency in cycles of both BRAMs from registered address to valid dout; legal range 1..7.
- RAM_DEPTH, 4096, program RAM size in bytes; power of two.
- VRAM_DEPTH, 256, VRAM size in bytes (8 bytes x 32 rows).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- req_valid_in  input  1  request strobe; honoured only while ready_out=1.
- req_we_in  input  1  1=write, 0=read.
- req_type_in  input  1  0=RAM, 1=VRAM.
- req_addr_in  input  16  byte address.
- req_data_in  input  8  write data.
- ready_out  output  1  responder idle and able to accept.
- resp_valid_out  output  1  one-cycle pulse, read data valid.
- resp_data_out  output  8  read data, held until the next response.
- err_out  output  1  sticky: an out-of-range address was seen.
- ram_addr_out  output  log2(RAM_DEPTH)  RAM address.
- ram_we_out  output  1  RAM write enable.
- ram_din_out  output  8  RAM write data.
- ram_dout_in  input  8  RAM read data.
- vram_addr_out  output  log2(VRAM_DEPTH)  VRAM address.
- vram_we_out  output  1  VRAM write enable.
- vram_din_out  output  8  VRAM write data.
- vram_dout_in  input  8  VRAM read data.

Behaviour:
- Reset and reset values:
  - All outputs are registered.
  - While rst_in=1: ready_out=0, resp_valid_out=0, resp_data_out=0, err_out=0, all BRAM we/addr/din=0, state=IDLE, latency counter=0.
  - ready_out rises at the first edge with rst_in=0.
- States:
  - IDLE: ready_out=1.
  - WRITE: one cycle.
  - READ_WAIT: counts BRAM_LATENCY edges.
  - RESP: one cycle.
- Accept: at edge A with state=IDLE and req_valid_in=1.
  - Latch the request and clear ready_out.
  - Drive the selected BRAM's addr (req_addr_in truncated to the port width), plus din and we when writing.
  - The unselected BRAM's we stays 0 and its address is unchanged.
- Write path:
  - At edge A+1: we falls, ready_out rises, state returns to IDLE.
  - ready_out is low for exactly 1 cycle.
  - No resp_valid_out pulse for writes.
- Read path:
  - Enter READ_WAIT at edge A with counter=0.
  - At edge A+BRAM_LATENCY+1: sample dout of the latched type's BRAM into resp_data_out, set resp_valid_out=1, go to RESP.
  - At edge A+BRAM_LATENCY+2: resp_valid_out=0, ready_out=1, state IDLE.
  - Total busy time is BRAM_LATENCY+2 cycles; with default latency, response at A+3 and ready again at A+4.
- Busy requests: req_valid_in while ready_out=0 is ignored and not queued. Initiators hold requests until they see ready_out=1.
- Range check:
  - RAM access with addr >= RAM_DEPTH, or VRAM access with addr >= VRAM_DEPTH, sets err_out=1 at edge A.
  - The access still proceeds using the truncated address, so it wraps.
  - err_out is cleared only by reset.
- Data hold: resp_data_out holds its value between responses and does not change on writes.
- Reset mid-operation: an in-flight read is dropped with no resp_valid_out pulse, and any write enable is deasserted in the same edge.
- Back-to-back: a request presented in the first IDLE cycle after a response or write is accepted on that edge, so there are no extra bubble cycles.

Test Plan:
- RAM write then read: write type=0 addr=0x0200 data=0xA5 accepted at edge A -> ram_we_out high for one cycle with ram_addr_out=0x200 and ready_out low for 1 cycle. Then read the same address accepted at edge B -> resp_valid_out single pulse at B+3 with resp_data_out=0xA5, ready_out=1 at B+4.
- Type isolation: write RAM 0x0010=0x11 and VRAM 0x0010=0x22 -> reading each returns 0x11 and 0x22 respectively, and vram_we_out never pulses during the RAM write.
- Busy drop: hold req_valid_in=1 continuously with varying addresses during a read -> only the request present at each ready_out=1 edge is accepted, with no duplicate responses.
- Range error: VRAM write addr=0x0105 data=0xFF -> vram_addr_out=0x05 written with 0xFF, err_out=1 and still 1 after further valid accesses.
- Reset mid-read: assert rst_in 1 cycle after accepting a read -> no resp_valid_out pulse, all outputs at reset values, ready_out=1 one edge after rst_in falls.
- Latency parameter: BRAM_LATENCY=1 with read accepted at A -> resp_valid_out at A+2, ready_out at A+3.
